// File: rtl/grouped_run_counter_pkg.sv
// Shared definitions for the grouped run counter: default geometry and the
// trailing-zero helper used to pick the coefficient bit.
package grouped_run_counter_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 4;
  localparam int NGROUPS   = DEF_WIDTH / DEF_GROUP;
  localparam int TZW       = $clog2(DEF_WIDTH);

  // Widest counter the trailing-zero helper can serve.
  localparam int MAXW   = 64;
  localparam int MAXTZW = $clog2(MAXW);

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic logic [MAXTZW-1:0] tz_index(input logic [MAXW-1:0] v);
    tz_index = '0;
    for (int i = MAXW - 1; i >= 0; i--) begin
      if (v[i]) tz_index = MAXTZW'(i);
    end
  endfunction

endpackage

// File: rtl/run_counter_slice.sv
// One carry group of the run counter: clear beats hold beats increment.
module run_counter_slice #(
  parameter int GROUP = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             carry_in,
  input  logic             clr,
  input  logic             hold,
  output logic [GROUP-1:0] q,
  output logic             all_ones,
  output logic             carry_out
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         q <= '0;
    else if (clr)      q <= '0;
    else if (hold)     q <= q;
    else if (carry_in) q <= q + 1'b1;
  end

  assign all_ones  = &q;
  assign carry_out = carry_in & all_ones;

endmodule

// File: rtl/grouped_run_counter.sv
// Run-length counter built from carry groups, with all-ones flags and a
// coefficient bit selected by the count's trailing-zero position.
module grouped_run_counter
  import grouped_run_counter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int GROUP     = 4,
  parameter int HOLD_IDLE = 0,
  parameter int SATURATE  = 0,
  parameter int Z_REG     = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             Clear,
  input  logic             X,
  input  logic [WIDTH:0]   C,
  output logic [WIDTH-1:0] count,
  output logic             W,
  output logic             TC,
  output logic             Z
);

  localparam int NG = WIDTH / GROUP;
  localparam int TW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_group
    $fatal(1, "grouped_run_counter: WIDTH must be a multiple of GROUP");
  end
  if (WIDTH > MAXW) begin : g_bad_width
    $fatal(1, "grouped_run_counter: WIDTH exceeds trailing-zero helper range");
  end

  logic [NG:0]   carry;
  logic [NG-1:0] grp_ones;
  logic          clr_all;
  logic          sat_hold;

  // X low without HOLD_IDLE restarts the run; Clear always wins.
  assign clr_all  = Clear | ((HOLD_IDLE == 0) & ~X);
  // carry[NG] is high exactly when an increment would wrap the whole counter.
  assign sat_hold = (SATURATE != 0) & carry[NG];
  assign carry[0] = X;

  for (genvar g = 0; g < NG; g++) begin : g_slice
    run_counter_slice #(.GROUP(GROUP)) u_slice (
      .clock     (clock),
      .reset     (reset),
      .carry_in  (carry[g]),
      .clr       (clr_all),
      .hold      (sat_hold),
      .q         (count[g*GROUP +: GROUP]),
      .all_ones  (grp_ones[g]),
      .carry_out (carry[g+1])
    );
  end

  assign W  = grp_ones[NG-1];
  assign TC = &grp_ones;

  logic [MAXW-1:0] count_ext;
  logic [TW-1:0]   tz;
  logic [TW:0]     sel;
  logic            z_pre;

  assign count_ext = MAXW'(count);
  assign tz        = TW'(tz_index(count_ext));
  assign sel       = {1'b0, tz} + 1'b1;
  assign z_pre     = X & (C[0] | ((|count) & C[sel]));

  if (Z_REG != 0) begin : g_zreg
    logic z_q;
    always_ff @(posedge clock or posedge reset) begin
      if (reset) z_q <= 1'b0;
      else       z_q <= z_pre;
    end
    assign Z = z_q;
  end else begin : g_zcomb
    assign Z = z_pre;
  end

endmodule

// File: tb/tb_grouped_run_counter.sv
// Directed bench over five parameterisations sharing one stimulus stream,
// plus an integer reference model compared on every falling edge.
module tb_grouped_run_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        x;
  logic [32:0] c;
  logic [8:0]  c8;
  assign c8 = c[8:0];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: default, b: 8-bit wrap, s: 8-bit saturate, d: 8-bit hold-idle, e: Z registered
  logic [31:0] cnt_a, cnt_e;
  logic [7:0]  cnt_b, cnt_s, cnt_d;
  logic w_a, tc_a, z_a, w_b, tc_b, z_b, w_s, tc_s, z_s, w_d, tc_d, z_d, w_e, tc_e, z_e;

  grouped_run_counter #(.WIDTH(32), .GROUP(4)) dut_a (
    .clock(clk), .reset(rst), .Clear(clear), .X(x), .C(c),
    .count(cnt_a), .W(w_a), .TC(tc_a), .Z(z_a));
  grouped_run_counter #(.WIDTH(8), .GROUP(4), .SATURATE(0)) dut_b (
    .clock(clk), .reset(rst), .Clear(clear), .X(x), .C(c8),
    .count(cnt_b), .W(w_b), .TC(tc_b), .Z(z_b));
  grouped_run_counter #(.WIDTH(8), .GROUP(4), .SATURATE(1)) dut_s (
    .clock(clk), .reset(rst), .Clear(clear), .X(x), .C(c8),
    .count(cnt_s), .W(w_s), .TC(tc_s), .Z(z_s));
  grouped_run_counter #(.WIDTH(8), .GROUP(4), .HOLD_IDLE(1)) dut_d (
    .clock(clk), .reset(rst), .Clear(clear), .X(x), .C(c8),
    .count(cnt_d), .W(w_d), .TC(tc_d), .Z(z_d));
  grouped_run_counter #(.WIDTH(32), .GROUP(4), .Z_REG(1)) dut_e (
    .clock(clk), .reset(rst), .Clear(clear), .X(x), .C(c),
    .count(cnt_e), .W(w_e), .TC(tc_e), .Z(z_e));

  // ---------------- reference model ----------------
  function automatic logic [63:0] m_next(logic [63:0] cnt, int width, int hold, int sat,
                                         logic clr_i, logic x_i);
    logic [63:0] top;
    top = (64'd1 << width) - 64'd1;
    if (clr_i) return 64'd0;
    if (!x_i) return (hold != 0) ? cnt : 64'd0;
    if (cnt == top) return (sat != 0) ? cnt : 64'd0;
    return cnt + 64'd1;
  endfunction

  function automatic logic m_z(logic [63:0] cnt, logic x_i, logic [32:0] c_i);
    if (!x_i) return 1'b0;
    if (c_i[0]) return 1'b1;
    for (int i = 0; i < 32; i++) if (cnt[i]) return c_i[i+1];
    return 1'b0;
  endfunction

  logic [63:0] ma, mb, ms, md, me;
  logic        mze;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= 0; mb <= 0; ms <= 0; md <= 0; me <= 0; mze <= 1'b0;
    end else begin
      ma  <= m_next(ma, 32, 0, 0, clear, x);
      mb  <= m_next(mb, 8, 0, 0, clear, x);
      ms  <= m_next(ms, 8, 0, 1, clear, x);
      md  <= m_next(md, 8, 1, 0, clear, x);
      me  <= m_next(me, 32, 0, 0, clear, x);
      mze <= m_z(me, x, c);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (cnt_a !== ma[31:0] || z_a !== m_z(ma, x, c) || tc_a !== (ma[31:0] == 32'hFFFF_FFFF)) begin
        errors++;
        $display("FAIL sb_a: count=%h Z=%b TC=%b expected count=%h Z=%b", cnt_a, z_a, tc_a, ma[31:0], m_z(ma, x, c));
      end
      checks++;
      if (cnt_b !== mb[7:0] || tc_b !== (mb[7:0] == 8'hFF) || w_b !== (mb[7:4] == 4'hF)) begin
        errors++;
        $display("FAIL sb_b: count=%h W=%b TC=%b expected count=%h", cnt_b, w_b, tc_b, mb[7:0]);
      end
      checks++;
      if (cnt_s !== ms[7:0] || cnt_d !== md[7:0]) begin
        errors++;
        $display("FAIL sb_sd: sat=%h hold=%h expected sat=%h hold=%h", cnt_s, cnt_d, ms[7:0], md[7:0]);
      end
      checks++;
      if (cnt_e !== me[31:0] || z_e !== mze) begin
        errors++;
        $display("FAIL sb_e: count=%h Z=%b expected count=%h Z=%b", cnt_e, z_e, me[31:0], mze);
      end
    end
  end

  // ---------------- directed tests ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (cnt_a !== 32'd0 || w_a !== 1'b0 || tc_a !== 1'b0 || z_a !== 1'b0 || z_e !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%h W=%b TC=%b Z=%b Ze=%b expected all zero", cnt_a, w_a, tc_a, z_a, z_e);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_run20();
    x = 1'b1;
    tick(20);
    checks++;
    if (cnt_a !== 32'h14 || w_a !== 1'b0 || tc_a !== 1'b0) begin
      errors++;
      $display("FAIL run20: count=%h W=%b TC=%b expected 14 0 0", cnt_a, w_a, tc_a);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    tick(255);
    checks++;
    if (cnt_b !== 8'hFF || w_b !== 1'b1 || tc_b !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: count=%h W=%b TC=%b expected ff 1 1", cnt_b, w_b, tc_b);
    end
    tick(1);
    checks++;
    if (cnt_b !== 8'h00 || w_b !== 1'b0 || tc_b !== 1'b0) begin
      errors++;
      $display("FAIL wrap_zero: count=%h W=%b TC=%b expected 00 0 0", cnt_b, w_b, tc_b);
    end
    checks++;
    if (cnt_s !== 8'hFF || tc_s !== 1'b1) begin
      errors++;
      $display("FAIL sat_256: count=%h TC=%b expected ff 1", cnt_s, tc_s);
    end
  endtask

  task automatic test_saturate();
    do_clear();
    tick(300);
    checks++;
    if (cnt_s !== 8'hFF || w_s !== 1'b1) begin
      errors++;
      $display("FAIL sat_300: count=%h W=%b expected ff 1", cnt_s, w_s);
    end
    checks++;
    if (cnt_b !== 8'd44 || cnt_a !== 32'd300) begin
      errors++;
      $display("FAIL wrap_300: b=%h a=%h expected 2c 12c", cnt_b, cnt_a);
    end
  endtask

  task automatic test_idle();
    do_clear();
    x = 1'b1;
    tick(5);
    checks++;
    if (cnt_a !== 32'd5 || cnt_d !== 8'd5) begin
      errors++;
      $display("FAIL idle_run: a=%h d=%h expected 5 5", cnt_a, cnt_d);
    end
    x = 1'b0;
    tick(1);
    checks++;
    if (cnt_a !== 32'd0 || cnt_d !== 8'd5) begin
      errors++;
      $display("FAIL idle_gap: a=%h d=%h expected 0 5", cnt_a, cnt_d);
    end
    x = 1'b1;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checks++;
    if (cnt_a !== 32'd0 || cnt_d !== 8'd0) begin
      errors++;
      $display("FAIL idle_clear: a=%h d=%h expected 0 0", cnt_a, cnt_d);
    end
  endtask

  task automatic test_zsel();
    do_clear();
    c = 33'd0;
    x = 1'b1;
    tick(12);
    c = 33'h8;
    #1;
    checks++;
    if (cnt_a !== 32'd12 || z_a !== 1'b1) begin
      errors++;
      $display("FAIL z_bit3: count=%h Z=%b expected c 1", cnt_a, z_a);
    end
    c = 33'h4;
    #1;
    checks++;
    if (z_a !== 1'b0) begin
      errors++;
      $display("FAIL z_bit2: Z=%b expected 0", z_a);
    end
    c = 33'h8;
    x = 1'b0;
    #1;
    checks++;
    if (z_a !== 1'b0) begin
      errors++;
      $display("FAIL z_xlow: Z=%b expected 0", z_a);
    end
    do_clear();
    c = 33'h1;
    x = 1'b1;
    #1;
    checks++;
    if (cnt_a !== 32'd0 || z_a !== 1'b1) begin
      errors++;
      $display("FAIL z_c0: count=%h Z=%b expected 0 1", cnt_a, z_a);
    end
  endtask

  task automatic test_zreg_reset();
    do_clear();
    c = 33'h8;
    x = 1'b1;
    tick(12);
    checks++;
    if (cnt_e !== 32'd12 || z_e !== 1'b0 || z_a !== 1'b1) begin
      errors++;
      $display("FAIL zreg_pre: count=%h Ze=%b Za=%b expected c 0 1", cnt_e, z_e, z_a);
    end
    tick(1);
    checks++;
    if (z_e !== 1'b1 || z_a !== 1'b0) begin
      errors++;
      $display("FAIL zreg_delay: Ze=%b Za=%b expected 1 0", z_e, z_a);
    end
    tick(1);
    checks++;
    if (z_e !== 1'b0) begin
      errors++;
      $display("FAIL zreg_after: Ze=%b expected 0", z_e);
    end
    do_clear();
    c = 33'hC;
    tick(7);
    checks++;
    if (cnt_e !== 32'd7 || z_e !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: count=%h Ze=%b expected 7 1", cnt_e, z_e);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (cnt_e !== 32'd0 || z_e !== 1'b0 || cnt_a !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: count=%h Ze=%b a=%h expected 0 0 0", cnt_e, z_e, cnt_a);
    end
    rst = 1'b0;
    tick(3);
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    x     = 1'b0;
    c     = 33'd0;
    test_reset();
    test_run20();
    test_wrap();
    test_saturate();
    test_idle();
    test_zsel();
    test_zreg_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
